// File: rtl/sync_edge_counter_pkg.sv
// Shared types and constants for the synchronous multi-channel edge counter.
// Edge-select encodings match the register-file field values.
package sync_edge_counter_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_t;

  localparam int MAX_NUM_SIG = 32;

  function automatic logic edgeQualify(input edge_mode_t mode,
                                       input logic       rise,
                                       input logic       fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_counter_channel.sv
// One channel: synchroniser chain, history flop, edge qualification and the
// wrap/saturate counter with its sticky overflow flag.
module edge_counter_channel
  import sync_edge_counter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  input  logic [1:0]       mode_i,
  input  logic             count_en_i,
  input  logic             saturate_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   syncSig, rise, fall, edgeHit;

  assign syncSig = syncChain_q[SYNC_STAGES-1];
  assign rise    = syncSig & ~prev_q;
  assign fall    = ~syncSig & prev_q;
  assign edgeHit = count_en_i & edgeQualify(edge_mode_t'(mode_i), rise, fall);

  // Synchroniser and history keep running even when counting is gated, so
  // re-enabling never sees a stale level difference as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      syncChain_q <= '0;
      prev_q      <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], sig_i};
      prev_q      <= syncSig;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (edgeHit) begin
      if (count_q == CNT_MAX) begin
        overflow_d = 1'b1;
        count_d    = saturate_i ? count_q : '0;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sync_edge_counter.sv
// Multi-channel synchronous edge counter: per-channel counters, a priming
// window after reset, and an atomic snapshot bank for the register file.
module sync_edge_counter
  import sync_edge_counter_pkg::*;
#(
  parameter int NUM_SIG     = 8,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     axi_clk,
  input  logic                     axi_resetn,
  input  logic [NUM_SIG-1:0]       input_signals,
  input  logic [1:0]               edge_mode,
  input  logic                     enable,
  input  logic                     saturate,
  input  logic                     clear,
  input  logic                     snapshot,
  output logic [NUM_SIG*CNT_W-1:0] count_live,
  output logic [NUM_SIG*CNT_W-1:0] count_snap,
  output logic                     snap_valid,
  output logic [NUM_SIG-1:0]       overflow
);

  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYCLES);
  localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(1);

  logic [PRIME_W-1:0]       primeCnt_q, primeCnt_d;
  logic                     primed, countEn;
  logic [NUM_SIG*CNT_W-1:0] countSnap_q, countSnap_d;
  logic                     snapValid_q;

  // Edges are ignored until the synchroniser and history hold real samples,
  // so a level present at reset release is never counted as an edge.
  assign primed     = (primeCnt_q == PRIME_DONE);
  assign primeCnt_d = primed ? primeCnt_q : primeCnt_q + PRIME_ONE;
  assign countEn    = primed & enable;

  for (genvar g = 0; g < NUM_SIG; g++) begin : g_chan
    edge_counter_channel #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_i     (axi_clk),
      .rst_ni    (axi_resetn),
      .sig_i     (input_signals[g]),
      .mode_i    (edge_mode),
      .count_en_i(countEn),
      .saturate_i(saturate),
      .clear_i   (clear),
      .count_o   (count_live[g*CNT_W +: CNT_W]),
      .overflow_o(overflow[g])
    );
  end

  // The snapshot captures the registered counts, i.e. the value before this
  // edge's update, which is what software sees with a coincident clear.
  assign countSnap_d = snapshot ? count_live : countSnap_q;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      primeCnt_q  <= '0;
      countSnap_q <= '0;
      snapValid_q <= 1'b0;
    end else begin
      primeCnt_q  <= primeCnt_d;
      countSnap_q <= countSnap_d;
      snapValid_q <= snapshot;
    end
  end

  assign count_snap = countSnap_q;
  assign snap_valid = snapValid_q;

endmodule

// File: tb/tb_sync_edge_counter.sv
// Randomised and directed bench for sync_edge_counter; a cycle-level model
// counts each driven input edge a fixed synchroniser latency later.
module tb_sync_edge_counter;

  localparam int NUM_SIG     = 4;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int BUS_W       = NUM_SIG * CNT_W;
  localparam int MAX_VAL     = (1 << CNT_W) - 1;

  logic               axi_clk = 1'b0;
  logic               axi_resetn;
  logic [NUM_SIG-1:0] input_signals;
  logic [1:0]         edge_mode;
  logic               enable, saturate, clear, snapshot;
  logic [BUS_W-1:0]   count_live, count_snap;
  logic               snap_valid;
  logic [NUM_SIG-1:0] overflow;

  sync_edge_counter #(
    .NUM_SIG    (NUM_SIG),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_resetn   (axi_resetn),
    .input_signals(input_signals),
    .edge_mode    (edge_mode),
    .enable       (enable),
    .saturate     (saturate),
    .clear        (clear),
    .snapshot     (snapshot),
    .count_live   (count_live),
    .count_snap   (count_snap),
    .snap_valid   (snap_valid),
    .overflow     (overflow)
  );

  always #5 axi_clk = ~axi_clk;

  int testsRun    = 0;
  int testsFailed = 0;

  int                 expLive[NUM_SIG];
  int                 expSnap[NUM_SIG];
  logic               expOvf[NUM_SIG];
  logic               expValid;
  logic [NUM_SIG-1:0] hist[$];
  int                 cyclesSinceReset;

  logic [NUM_SIG-1:0] curSig;
  logic [1:0]         curMode;
  logic               curEn, curSat;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] packCounts(input int vals[NUM_SIG]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_SIG; i++) v[i*CNT_W +: CNT_W] = CNT_W'(vals[i]);
    return v;
  endfunction

  function automatic logic [31:0] packOvf();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_SIG; i++) v[i] = expOvf[i];
    return v;
  endfunction

  // An input change driven before edge k is acted on at edge k+2; the model
  // applies the spec's per-cycle rules to that delayed edge.
  task automatic modelEdge();
    int n;
    logic cur, old, qual;
    n = hist.size();
    cyclesSinceReset++;
    if (snapshot) expSnap = expLive;
    expValid = snapshot;
    for (int i = 0; i < NUM_SIG; i++) begin
      cur = hist[n-3][i];
      old = hist[n-4][i];
      case (curMode)
        2'b00:   qual = cur & ~old;
        2'b01:   qual = ~cur & old;
        2'b10:   qual = cur ^ old;
        default: qual = 1'b0;
      endcase
      if (clear) begin
        expLive[i] = 0;
        expOvf[i]  = 1'b0;
      end else if (qual && curEn && cyclesSinceReset >= SYNC_STAGES + 2) begin
        if (expLive[i] == MAX_VAL) begin
          expOvf[i] = 1'b1;
          if (!curSat) expLive[i] = 0;
        end else begin
          expLive[i] = expLive[i] + 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [NUM_SIG-1:0] sig, input logic clr,
                               input logic snp);
    @(negedge axi_clk);
    curSig        = sig;
    input_signals = sig;
    edge_mode     = curMode;
    enable        = curEn;
    saturate      = curSat;
    clear         = clr;
    snapshot      = snp;
    hist.push_back(sig);
    if (hist.size() > 8) void'(hist.pop_front());
    @(posedge axi_clk);
    modelEdge();
    #1;
    checkOutput("live",  32'(count_live), packCounts(expLive));
    checkOutput("snap",  32'(count_snap), packCounts(expSnap));
    checkOutput("ovf",   32'(overflow),   packOvf());
    checkOutput("valid", 32'(snap_valid), 32'(expValid));
  endtask

  task automatic doReset(input logic [NUM_SIG-1:0] held);
    axi_resetn    = 1'b0;
    input_signals = held;
    curSig        = held;
    clear         = 1'b0;
    snapshot      = 1'b0;
    edge_mode     = curMode;
    enable        = curEn;
    saturate      = curSat;
    repeat (3) @(negedge axi_clk);
    checkOutput("rst_live",  32'(count_live), 32'h0);
    checkOutput("rst_snap",  32'(count_snap), 32'h0);
    checkOutput("rst_ovf",   32'(overflow),   32'h0);
    checkOutput("rst_valid", 32'(snap_valid), 32'h0);
    for (int i = 0; i < NUM_SIG; i++) begin
      expLive[i] = 0;
      expSnap[i] = 0;
      expOvf[i]  = 1'b0;
    end
    expValid = 1'b0;
    cyclesSinceReset = 0;
    hist.delete();
    repeat (4) hist.push_back(held);
    @(posedge axi_clk);
    #2 axi_resetn = 1'b1;
  endtask

  task automatic pulses(input int ch, input int n, input int hi, input int lo);
    logic [NUM_SIG-1:0] s;
    for (int p = 0; p < n; p++) begin
      s = curSig;
      s[ch] = 1'b1;
      repeat (hi) applyStimulus(s, 1'b0, 1'b0);
      s[ch] = 1'b0;
      repeat (lo) applyStimulus(s, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int lat;
    int age[NUM_SIG];
    logic [NUM_SIG-1:0] nxt;

    curMode = 2'b10;
    curEn   = 1'b1;
    curSat  = 1'b0;

    // Inputs high through reset must not produce a count, even in both-edge mode
    doReset('1);
    repeat (20) applyStimulus('1, 1'b0, 1'b0);
    checkOutput("prime_live", 32'(count_live), 32'h0);
    checkOutput("prime_ovf",  32'(overflow),   32'h0);
    repeat (4) applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);

    // Rising mode: 5 pulses on channel 0 with the first-increment latency
    curMode = 2'b00;
    applyStimulus('0, 1'b1, 1'b0);
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      if (lat == 0 && count_live[CNT_W-1:0] != '0) lat = c;
    end
    checkOutput("rise_latency", 32'(lat >= 3 && lat <= 4), 32'h1);
    repeat (4) applyStimulus(4'b0000, 1'b0, 1'b0);
    pulses(0, 4, 4, 4);
    checkOutput("rise_ch0",    32'(count_live[CNT_W-1:0]), 32'd5);
    checkOutput("rise_others", 32'(count_live[BUS_W-1:CNT_W]), 32'h0);

    // The same 3 pulses in both, falling and none modes
    curMode = 2'b10;
    applyStimulus('0, 1'b1, 1'b0);
    pulses(0, 3, 4, 4);
    checkOutput("mode_both", 32'(count_live[CNT_W-1:0]), 32'd6);
    curMode = 2'b01;
    applyStimulus('0, 1'b1, 1'b0);
    pulses(0, 3, 4, 4);
    checkOutput("mode_fall", 32'(count_live[CNT_W-1:0]), 32'd3);
    curMode = 2'b11;
    applyStimulus('0, 1'b1, 1'b0);
    pulses(0, 3, 4, 4);
    checkOutput("mode_none", 32'(count_live[CNT_W-1:0]), 32'd0);

    // Overflow: wrap, then saturate, then clear
    curMode = 2'b00;
    curSat  = 1'b0;
    applyStimulus('0, 1'b1, 1'b0);
    pulses(0, 17, 2, 2);
    checkOutput("wrap_count", 32'(count_live[CNT_W-1:0]), 32'd1);
    checkOutput("wrap_ovf",   32'(overflow[0]), 32'h1);
    curSat = 1'b1;
    applyStimulus('0, 1'b1, 1'b0);
    pulses(0, 17, 2, 2);
    checkOutput("sat_count", 32'(count_live[CNT_W-1:0]), 32'd15);
    checkOutput("sat_ovf",   32'(overflow[0]), 32'h1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("clr_count", 32'(count_live[CNT_W-1:0]), 32'd0);
    checkOutput("clr_ovf",   32'(overflow[0]), 32'h0);

    // Clear and snapshot together on the edge where a rise would count
    curSat = 1'b0;
    pulses(0, 7, 2, 2);
    checkOutput("coin_pre", 32'(count_live[CNT_W-1:0]), 32'd7);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    checkOutput("coin_snap",  32'(count_snap[CNT_W-1:0]), 32'd7);
    checkOutput("coin_live",  32'(count_live[CNT_W-1:0]), 32'd0);
    checkOutput("coin_valid", 32'(snap_valid), 32'h1);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("coin_valid_drop", 32'(snap_valid), 32'h0);
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Gating: disabled pulses are lost; re-enabling while high adds nothing
    pulses(0, 2, 2, 2);
    checkOutput("gate_pre", 32'(count_live[CNT_W-1:0]), 32'd2);
    curEn = 1'b0;
    pulses(0, 4, 2, 2);
    repeat (4) applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("gate_off", 32'(count_live[CNT_W-1:0]), 32'd2);
    curEn = 1'b1;
    repeat (4) applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("gate_reenable", 32'(count_live[CNT_W-1:0]), 32'd2);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (4) applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("gate_genuine", 32'(count_live[CNT_W-1:0]), 32'd3);

    // Random traffic on all channels with random controls
    for (int i = 0; i < NUM_SIG; i++) age[i] = 2;
    for (int c = 0; c < 600; c++) begin
      nxt = curSig;
      for (int i = 0; i < NUM_SIG; i++) begin
        age[i]++;
        if (age[i] >= 2 && $urandom_range(2) == 0) begin
          nxt[i] = ~nxt[i];
          age[i] = 0;
        end
      end
      if ($urandom_range(15) == 0) curMode = 2'($urandom_range(3));
      curEn = ($urandom_range(9) != 0);
      if ($urandom_range(31) == 0) curSat = ~curSat;
      applyStimulus(nxt, ($urandom_range(39) == 0), ($urandom_range(7) == 0));
    end

    // Second reset with a random held level, then more random traffic
    curMode = 2'b10;
    curEn   = 1'b1;
    doReset(NUM_SIG'($urandom_range(15)));
    repeat (8) applyStimulus(curSig, 1'b0, 1'b0);
    checkOutput("reprime_live", 32'(count_live), 32'h0);
    for (int i = 0; i < NUM_SIG; i++) age[i] = 2;
    for (int c = 0; c < 300; c++) begin
      nxt = curSig;
      for (int i = 0; i < NUM_SIG; i++) begin
        age[i]++;
        if (age[i] >= 2 && $urandom_range(1) == 0) begin
          nxt[i] = ~nxt[i];
          age[i] = 0;
        end
      end
      applyStimulus(nxt, ($urandom_range(63) == 0), ($urandom_range(3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
